// File: rtl/accel_axis_averager.sv
// Block-averages signed Y/Z accelerometer samples and launches the CORDIC
// tilt stage, buffering one finished average while the stage is busy.
module accel_axis_averager #(
  parameter int unsigned IN_WIDTH = 12,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned LOG2_AVG = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [IN_WIDTH-1:0] i_y_raw,
  input  logic [IN_WIDTH-1:0] i_z_raw,
  input  logic                i_sample_valid,
  input  logic                i_cordic_done,
  output logic [WIDTH-1:0]    o_y,
  output logic [WIDTH-1:0]    o_z,
  output logic                o_start,
  output logic                o_busy,
  output logic                o_overrun
);

  localparam int unsigned AW = IN_WIDTH + LOG2_AVG;
  // A zero-width counter is illegal, so LOG2_AVG=0 keeps one bit pinned at 0.
  localparam int unsigned CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int unsigned N  = 1 << LOG2_AVG;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                      state, state_n;
  logic                        launch;
  logic                        done_q;
  logic                        done_rise;
  logic                        pending;
  logic [CW-1:0]               count;
  logic signed [AW-1:0]        acc_y, acc_z;
  logic signed [AW-1:0]        y_ext, z_ext;
  logic signed [AW-1:0]        sum_y, sum_z;
  logic signed [IN_WIDTH-1:0]  res_y, res_z;
  logic                        block_done;

  assign y_ext      = AW'($signed(i_y_raw));
  assign z_ext      = AW'($signed(i_z_raw));
  assign sum_y      = acc_y + y_ext;
  assign sum_z      = acc_z + z_ext;
  assign block_done = i_sample_valid && (count == CW'(N - 1));
  assign done_rise  = i_cordic_done && !done_q;

  // Accumulate samples, latch each finished average and track overwrite.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_y     <= '0;
      acc_z     <= '0;
      count     <= '0;
      res_y     <= '0;
      res_z     <= '0;
      pending   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (block_done) begin
        res_y   <= IN_WIDTH'(sum_y >>> LOG2_AVG);
        res_z   <= IN_WIDTH'(sum_z >>> LOG2_AVG);
        acc_y   <= '0;
        acc_z   <= '0;
        count   <= '0;
        pending <= 1'b1;
        if (pending && !launch) begin
          o_overrun <= 1'b1;
        end
      end else begin
        if (i_sample_valid) begin
          acc_y <= sum_y;
          acc_z <= sum_z;
          count <= count + CW'(1);
        end
        if (launch) begin
          pending <= 1'b0;
        end
      end
    end
  end

  // Launch FSM state, done history and registered launch outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      done_q  <= 1'b0;
      o_start <= 1'b0;
      o_busy  <= 1'b0;
      o_y     <= '0;
      o_z     <= '0;
    end else begin
      state   <= state_n;
      done_q  <= i_cordic_done;
      o_start <= launch;
      o_busy  <= (state_n == S_WAIT);
      if (launch) begin
        o_y <= WIDTH'(res_y);
        o_z <= WIDTH'(res_z);
      end
    end
  end

  // Next state: launch a pending average from IDLE, leave WAIT on done rising.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          launch  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_accel_axis_averager.sv
// Directed bench for accel_axis_averager with hand-computed expectations.
module tb_accel_axis_averager;

  localparam int unsigned IN_WIDTH = 12;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned LOG2_AVG = 3;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [IN_WIDTH-1:0] i_y_raw = '0;
  logic [IN_WIDTH-1:0] i_z_raw = '0;
  logic                i_sample_valid = 1'b0;
  logic                i_cordic_done = 1'b0;
  logic [WIDTH-1:0]    o_y, o_z;
  logic                o_start, o_busy, o_overrun;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int s0;

  accel_axis_averager #(
    .IN_WIDTH (IN_WIDTH),
    .WIDTH    (WIDTH),
    .LOG2_AVG (LOG2_AVG)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_y_raw        (i_y_raw),
    .i_z_raw        (i_z_raw),
    .i_sample_valid (i_sample_valid),
    .i_cordic_done  (i_cordic_done),
    .o_y            (o_y),
    .o_z            (o_z),
    .o_start        (o_start),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Count launch pulses away from the active edge.
  always @(negedge i_clk) begin
    if (o_start === 1'b1) n_start++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input int y, input int z);
    i_y_raw        = IN_WIDTH'(y);
    i_z_raw        = IN_WIDTH'(z);
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input int y, input int z);
    for (int i = 0; i < n; i++) send(y, z);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic done_pulse();
    i_cordic_done = 1'b1;
    tick();
    i_cordic_done = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values
    tick();
    do_reset();
    check("rst_y", 32'(o_y), 32'h0);
    check("rst_z", 32'(o_z), 32'h0);
    check("rst_start", 32'(o_start), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_ovr", 32'(o_overrun), 32'h0);

    // 1: constant block
    s0 = n_start;
    send_n(8, 100, -50);
    check("t1_nostart_yet", 32'(o_start), 32'h0);
    tick();
    check("t1_start", 32'(o_start), 32'h1);
    check("t1_y", 32'(o_y), 32'h0064);
    check("t1_z", 32'(o_z), 32'hFFCE);
    check("t1_busy", 32'(o_busy), 32'h1);
    tick();
    check("t1_start_once", 32'(o_start), 32'h0);
    check("t1_busy_hold", 32'(o_busy), 32'h1);
    check("t1_nstart", 32'(n_start - s0), 32'd1);
    i_cordic_done = 1'b1;
    tick();
    check("t1_busy_clr", 32'(o_busy), 32'h0);
    i_cordic_done = 1'b0;
    tick();

    // 2: floor toward -infinity
    for (int i = 0; i < 7; i++) send(i, -1);
    send(7, -2);
    tick();
    check("t2_start", 32'(o_start), 32'h1);
    check("t2_y", 32'(o_y), 32'h0003);
    check("t2_z", 32'(o_z), 32'hFFFE);
    done_pulse();

    // 3: extremes
    send_n(8, 'h800, 'h7FF);
    tick();
    check("t3_y", 32'(o_y), 32'hF800);
    check("t3_z", 32'(o_z), 32'h07FF);
    done_pulse();

    // 4: backpressure and overrun
    s0 = n_start;
    send_n(8, 1, 2);
    send_n(8, 3, 4);
    send_n(8, 5, 6);
    check("t4_nstart", 32'(n_start - s0), 32'd1);
    check("t4_ovr", 32'(o_overrun), 32'h1);
    check("t4_y_held", 32'(o_y), 32'h0001);
    check("t4_busy", 32'(o_busy), 32'h1);
    i_cordic_done = 1'b1;
    tick();
    check("t4_busy_clr", 32'(o_busy), 32'h0);
    i_cordic_done = 1'b0;
    tick();
    check("t4_start_c", 32'(o_start), 32'h1);
    check("t4_y_c", 32'(o_y), 32'h0005);
    check("t4_z_c", 32'(o_z), 32'h0006);
    done_pulse();

    // 5: launch of B coincides with completion of C
    do_reset();
    check("t5_ovr_rst", 32'(o_overrun), 32'h0);
    send_n(8, 7, 8);
    tick();
    check("t5_start_a", 32'(o_start), 32'h1);
    send_n(8, 9, -3);
    send_n(7, 11, 12);
    i_cordic_done = 1'b1;
    tick();
    i_cordic_done  = 1'b0;
    i_y_raw        = IN_WIDTH'(11);
    i_z_raw        = IN_WIDTH'(12);
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    check("t5_start_b", 32'(o_start), 32'h1);
    check("t5_y_b", 32'(o_y), 32'h0009);
    check("t5_z_b", 32'(o_z), 32'hFFFD);
    check("t5_ovr", 32'(o_overrun), 32'h0);
    tick();
    check("t5_start_off", 32'(o_start), 32'h0);
    i_cordic_done = 1'b1;
    tick();
    i_cordic_done = 1'b0;
    tick();
    check("t5_start_c", 32'(o_start), 32'h1);
    check("t5_y_c", 32'(o_y), 32'h000B);
    check("t5_z_c", 32'(o_z), 32'h000C);
    check("t5_ovr_end", 32'(o_overrun), 32'h0);
    done_pulse();

    // 6: reset mid-block
    send_n(5, 500, 500);
    do_reset();
    check("t6_y_rst", 32'(o_y), 32'h0);
    check("t6_busy_rst", 32'(o_busy), 32'h0);
    check("t6_start_rst", 32'(o_start), 32'h0);
    s0 = n_start;
    send_n(7, 10, 10);
    tick();
    check("t6_no_early", 32'(n_start - s0), 32'd0);
    send(10, 10);
    tick();
    check("t6_start", 32'(o_start), 32'h1);
    check("t6_y", 32'(o_y), 32'h000A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
